// File: rtl/exc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exc_redirect_ctrl
// Purpose  : Exception/ERET redirect sequencer. Flushes the pipeline, drains
//            outstanding instruction-bus requests (marking stale responses for
//            discard), then presents the handler vector or EPC to fetch.
// Revision : 1.0 - initial release
// ============================================================================
module exc_redirect_ctrl #(
    parameter int          OUTST_W  = 3,
    parameter logic [31:0] VEC_BEV1 = 32'hBFC00380,
    parameter logic [31:0] VEC_BEV0 = 32'h80000180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_valid,
    input  logic        ws_exc,
    input  logic        ws_eret,
    input  logic [31:0] cp0_epc,
    input  logic        cp0_bev,
    input  logic        inst_req_ok,
    input  logic        inst_data_ok,
    input  logic        redirect_ready,
    output logic        flush,
    output logic        fetch_hold,
    output logic        discard_resp,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic        cnt_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [OUTST_W-1:0] CNT_MAX  = '1;
    localparam logic [OUTST_W-1:0] CNT_ZERO = '0;
    localparam logic [OUTST_W-1:0] CNT_ONE  = {{(OUTST_W-1){1'b0}}, 1'b1};

    state_t             state;
    state_t             state_next;
    logic [OUTST_W-1:0] cnt;
    logic [OUTST_W-1:0] cnt_next;
    logic               cnt_ovf;
    logic               cnt_unf;
    logic [31:0]        target;
    logic [31:0]        target_next;
    logic               evt;

    assign evt = ws_valid && (ws_exc || ws_eret);

    // Outstanding-request counter: saturates at both ends and flags misuse.
    always_comb begin
        cnt_next = cnt;
        cnt_ovf  = 1'b0;
        cnt_unf  = 1'b0;
        if (inst_req_ok && !inst_data_ok) begin
            if (cnt == CNT_MAX) begin
                cnt_ovf = 1'b1;
            end else begin
                cnt_next = cnt + CNT_ONE;
            end
        end else if (!inst_req_ok && inst_data_ok) begin
            if (cnt == CNT_ZERO) begin
                cnt_unf = 1'b1;
            end else begin
                cnt_next = cnt - CNT_ONE;
            end
        end
    end

    // Next-state, target capture and the two combinational outputs.
    always_comb begin
        state_next   = state;
        target_next  = target;
        flush        = 1'b0;
        discard_resp = 1'b0;
        case (state)
            IDLE: begin
                if (evt) begin
                    flush = 1'b1;
                    // Exception has priority over ERET when both are flagged.
                    if (ws_exc) begin
                        target_next = cp0_bev ? VEC_BEV1 : VEC_BEV0;
                    end else begin
                        target_next = cp0_epc;
                    end
                    state_next = (cnt_next != CNT_ZERO) ? DRAIN : REDIRECT;
                end
            end
            DRAIN: begin
                // Every response seen here belongs to the flushed stream.
                discard_resp = inst_data_ok;
                if (cnt_next == CNT_ZERO) begin
                    state_next = REDIRECT;
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counter, sticky error and latched target.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= CNT_ZERO;
            cnt_err <= 1'b0;
            target  <= 32'h0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            cnt_err <= cnt_err | cnt_ovf | cnt_unf;
            target  <= target_next;
        end
    end

    // Registered outputs derived from the upcoming state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_hold     <= 1'b0;
            busy           <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0;
        end else begin
            fetch_hold     <= (state_next != IDLE);
            busy           <= (state_next != IDLE);
            redirect_valid <= (state_next == REDIRECT);
            redirect_pc    <= (state_next == REDIRECT) ? target_next : 32'h0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exc_redirect_ctrl
// Purpose  : Self-checking bench: directed vector table, hand-written counter
//            corner sequences and randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exc_redirect_ctrl;

    localparam logic [31:0] V1 = 32'hBFC00380;
    localparam logic [31:0] V0 = 32'h80000180;
    localparam int          MAXC = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_valid, ws_exc, ws_eret, cp0_bev;
    logic [31:0] cp0_epc;
    logic        inst_req_ok, inst_data_ok, redirect_ready;
    logic        flush, fetch_hold, discard_resp, redirect_valid, busy, cnt_err;
    logic [31:0] redirect_pc;

    int tests = 0;
    int fails = 0;

    exc_redirect_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .ws_valid       (ws_valid),
        .ws_exc         (ws_exc),
        .ws_eret        (ws_eret),
        .cp0_epc        (cp0_epc),
        .cp0_bev        (cp0_bev),
        .inst_req_ok    (inst_req_ok),
        .inst_data_ok   (inst_data_ok),
        .redirect_ready (redirect_ready),
        .flush          (flush),
        .fetch_hold     (fetch_hold),
        .discard_resp   (discard_resp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
        .cnt_err        (cnt_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  in;   // {valid, exc, eret, bev, req_ok, data_ok, ready}
        logic [31:0] epc;
        logic [4:0]  out;  // {flush, discard, busy, redirect_valid, cnt_err}
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mk(input logic [6:0] i, input logic [31:0] e,
                                input logic [4:0] o, input logic [31:0] p);
        vec_t v;
        v.in = i; v.epc = e; v.out = o; v.pc = p;
        return v;
    endfunction

    task automatic set_in(input logic [6:0] i, input logic [31:0] e);
        {ws_valid, ws_exc, ws_eret, cp0_bev, inst_req_ok, inst_data_ok, redirect_ready} = i;
        cp0_epc = e;
    endtask

    // Packed view: {flush, discard, busy, fetch_hold, redirect_valid, cnt_err, pc}
    function automatic logic [37:0] outs();
        return {flush, discard_resp, busy, fetch_hold, redirect_valid, cnt_err, redirect_pc};
    endfunction

    function automatic logic [37:0] expv(input logic [4:0] o, input logic [31:0] p);
        return {o[4], o[3], o[2], o[2], o[1], o[0], p};
    endfunction

    task automatic chk(input string name, input logic [37:0] got, input logic [37:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got fl/dc/bz/fh/rv/er/pc=%b%b%b%b%b%b/%h required %b%b%b%b%b%b/%h",
                     name, got[37], got[36], got[35], got[34], got[33], got[32], got[31:0],
                     exp[37], exp[36], exp[35], exp[34], exp[33], exp[32], exp[31:0]);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(7'b0, 32'h0);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    // Reference model state: an event is pending until its redirect is taken;
    // "drained" records that the outstanding count has returned to zero.
    bit          m_pend, m_drained, m_err;
    int          m_cnt;
    logic [31:0] m_tgt;

    function automatic logic [37:0] model_exp();
        logic evt, rv;
        evt = ws_valid && (ws_exc || ws_eret);
        rv  = m_pend && m_drained;
        return {!m_pend && evt, m_pend && !m_drained && inst_data_ok, m_pend, m_pend,
                rv, m_err, rv ? m_tgt : 32'h0};
    endfunction

    task automatic model_step();
        int  c;
        logic evt;
        evt = ws_valid && (ws_exc || ws_eret);
        if (reset) begin
            m_pend = 0; m_drained = 0; m_err = 0; m_cnt = 0; m_tgt = 32'h0;
            return;
        end
        c = m_cnt + int'(inst_req_ok) - int'(inst_data_ok);
        if (c > MAXC) begin c = MAXC; m_err = 1; end
        if (c < 0)    begin c = 0;    m_err = 1; end
        if (!m_pend && evt) begin
            m_pend    = 1;
            m_tgt     = ws_exc ? (cp0_bev ? V1 : V0) : cp0_epc;
            m_drained = (c == 0);
        end else if (m_pend && !m_drained) begin
            if (c == 0) m_drained = 1;
        end else if (m_pend && m_drained && redirect_ready) begin
            m_pend = 0; m_drained = 0;
        end
        m_cnt = c;
    endtask

    initial begin
        tbl[0]  = mk(7'b0000000, 32'h0,        5'b00000, 32'h0);
        tbl[1]  = mk(7'b1101001, 32'h0,        5'b10000, 32'h0);
        tbl[2]  = mk(7'b0000001, 32'h0,        5'b00110, V1);
        tbl[3]  = mk(7'b0000000, 32'h0,        5'b00000, 32'h0);
        tbl[4]  = mk(7'b0000100, 32'h0,        5'b00000, 32'h0);
        tbl[5]  = mk(7'b0000100, 32'h0,        5'b00000, 32'h0);
        tbl[6]  = mk(7'b1010001, 32'h1FC01234, 5'b10000, 32'h0);
        tbl[7]  = mk(7'b0000000, 32'h0,        5'b00100, 32'h0);
        tbl[8]  = mk(7'b0000010, 32'h0,        5'b01100, 32'h0);
        tbl[9]  = mk(7'b0000000, 32'h0,        5'b00100, 32'h0);
        tbl[10] = mk(7'b0000010, 32'h0,        5'b01100, 32'h0);
        tbl[11] = mk(7'b0000001, 32'h0,        5'b00110, 32'h1FC01234);
        tbl[12] = mk(7'b0000000, 32'h0,        5'b00000, 32'h0);
        tbl[13] = mk(7'b1110000, 32'hDEADBEEF, 5'b10000, 32'h0);
        for (int k = 14; k <= 18; k++)
            tbl[k] = mk(7'b0000000, 32'h0,     5'b00110, V0);
        tbl[19] = mk(7'b0000001, 32'h0,        5'b00110, V0);
        tbl[20] = mk(7'b0000000, 32'h0,        5'b00000, 32'h0);
        tbl[21] = mk(7'b0000100, 32'h0,        5'b00000, 32'h0);
        tbl[22] = mk(7'b1010000, 32'h11112222, 5'b10000, 32'h0);
        tbl[23] = mk(7'b1010000, 32'h33334444, 5'b00100, 32'h0);
        tbl[24] = mk(7'b0000110, 32'h0,        5'b01100, 32'h0);
        tbl[25] = mk(7'b0000010, 32'h0,        5'b01100, 32'h0);
        tbl[26] = mk(7'b0000001, 32'h0,        5'b00110, 32'h11112222);
        tbl[27] = mk(7'b0000000, 32'h0,        5'b00000, 32'h0);

        reset = 1'b1;
        set_in(7'b0, 32'h0);
        next_cycle();
        next_cycle();
        reset = 1'b0;

        // Directed vector table.
        for (int k = 0; k < 28; k++) begin
            set_in(tbl[k].in, tbl[k].epc);
            @(negedge clk);
            chk($sformatf("vec%0d", k), outs(), expv(tbl[k].out, tbl[k].pc));
            next_cycle();
        end

        // Saturation: 8 increments must stop at 7 and flag an error.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            set_in(7'b0000100, 32'h0);
            next_cycle();
        end
        set_in(7'b0, 32'h0);
        @(negedge clk);
        chk("sat_err", outs(), expv(5'b00001, 32'h0));
        next_cycle();
        set_in(7'b1100000, 32'h0);        // exception, BEV=0
        @(negedge clk);
        chk("sat_evt", outs(), expv(5'b10001, 32'h0));
        next_cycle();
        for (int k = 0; k < 7; k++) begin
            set_in(7'b0000010, 32'h0);
            @(negedge clk);
            chk($sformatf("sat_drain%0d", k), outs(), expv(5'b01101, 32'h0));
            next_cycle();
        end
        set_in(7'b0000001, 32'h0);
        @(negedge clk);
        chk("sat_redir", outs(), expv(5'b00111, V0));
        next_cycle();

        // Underflow: data_ok with nothing outstanding.
        do_reset();
        @(negedge clk);
        chk("unf_pre", outs(), expv(5'b00000, 32'h0));
        next_cycle();
        set_in(7'b0000010, 32'h0);
        next_cycle();
        set_in(7'b0, 32'h0);
        @(negedge clk);
        chk("unf_err", outs(), expv(5'b00001, 32'h0));
        next_cycle();

        // Reset while redirecting aborts with no redirect issued afterwards.
        do_reset();
        set_in(7'b1101000, 32'h0);
        next_cycle();
        set_in(7'b0, 32'h0);
        @(negedge clk);
        chk("rst_redir", outs(), expv(5'b00110, V1));
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_after%0d", k), outs(), expv(5'b00000, 32'h0));
            next_cycle();
        end

        // Randomized traffic against the reference model.
        do_reset();
        m_pend = 0; m_drained = 0; m_err = 0; m_cnt = 0; m_tgt = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            reset          = ($urandom_range(0, 249) == 0);
            ws_valid       = ($urandom_range(0, 5) == 0);
            ws_exc         = $urandom_range(0, 1) == 1;
            ws_eret        = $urandom_range(0, 1) == 1;
            cp0_bev        = $urandom_range(0, 1) == 1;
            cp0_epc        = $urandom;
            inst_req_ok    = ($urandom_range(0, 2) == 0);
            inst_data_ok   = ($urandom_range(0, 2) == 0);
            redirect_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            chk($sformatf("rnd%0d", n), outs(), model_exp());
            model_step();
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
